// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush scheduler for the 5-stage in-order pipeline.
// Tracks outstanding data-bus accesses so a trap never abandons an in-flight load/store.
module pipeline_hazard_ctrl #(
    parameter int unsigned REG_ADDRWIDTH = 5,
    parameter int unsigned CNT_WIDTH     = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [REG_ADDRWIDTH-1:0] id_rs1_idx_i,
    input  logic [REG_ADDRWIDTH-1:0] id_rs2_idx_i,
    input  logic [REG_ADDRWIDTH-1:0] ex_rd_idx_i,
    input  logic                     ex_is_load_i,
    input  logic                     ex_branch_taken_i,
    input  logic [63:0]              ex_branch_target_i,
    input  logic                     if_busy_i,
    input  logic                     mem_req_fire_i,
    input  logic                     mem_resp_valid_i,
    input  logic                     mem_trap_valid_i,
    input  logic [63:0]              trap_vector_i,
    output logic [5:0]               stall_valid_o,
    output logic [5:0]               flush_valid_o,
    output logic                     redirect_valid_o,
    output logic [63:0]              redirect_pc_o,
    output logic [CNT_WIDTH-1:0]     stall_cycles_o
);

    typedef enum logic [1:0] {StRun, StMemWait, StTrapWait} state_e;

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    logic load_use;
    logic trap_redirect;
    logic mem_wait;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun: begin
                if (mem_req_fire_i && !mem_resp_valid_i) state_d = StMemWait;
            end
            StMemWait: begin
                if (mem_resp_valid_i)      state_d = StRun;
                else if (mem_trap_valid_i) state_d = StTrapWait;
            end
            StTrapWait: begin
                if (mem_resp_valid_i) state_d = StRun;
            end
            default: state_d = StRun;
        endcase
    end

    assign load_use = ex_is_load_i && (ex_rd_idx_i != '0) &&
                      ((ex_rd_idx_i == id_rs1_idx_i) || (ex_rd_idx_i == id_rs2_idx_i));

    // A trap seen during MEM_WAIT is only acted on once the response lands in TRAP_WAIT.
    assign trap_redirect = ((state_q == StRun) && mem_trap_valid_i) ||
                           ((state_q == StTrapWait) && mem_resp_valid_i);

    assign mem_wait = !mem_resp_valid_i &&
                      ((state_q != StRun) || mem_req_fire_i);

    always_comb begin
        stall_valid_o    = 6'b000000;
        flush_valid_o    = 6'b000000;
        redirect_valid_o = 1'b0;
        redirect_pc_o    = 64'd0;
        if (!rst) begin
            stall_valid_o = 6'b000000;
        end else if (trap_redirect) begin
            flush_valid_o    = 6'b011110;
            redirect_valid_o = 1'b1;
            redirect_pc_o    = trap_vector_i;
        end else if (mem_wait) begin
            stall_valid_o = 6'b001111;
            flush_valid_o = 6'b010000;
        end else if (ex_branch_taken_i) begin
            flush_valid_o    = 6'b000110;
            redirect_valid_o = 1'b1;
            redirect_pc_o    = ex_branch_target_i;
        end else if (load_use) begin
            stall_valid_o = 6'b000011;
            flush_valid_o = 6'b000100;
        end else if (if_busy_i) begin
            stall_valid_o = 6'b000001;
            flush_valid_o = 6'b000010;
        end
    end

    // Free-running and wrapping by design; software reads deltas.
    always_comb begin
        cnt_d = cnt_q;
        if (stall_valid_o[0]) cnt_d = cnt_q + CNT_WIDTH'(1);
    end

    assign stall_cycles_o = cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StRun;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: expectations are queued as stimulus is
// driven and popped when the combinational outputs are sampled mid-cycle.
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        ex_ld, br, busy, fire, resp, trap;
    logic [63:0] bt, tv;
    logic [5:0]  stall, flush, stall4, flush4;
    logic        rv, rv4;
    logic [63:0] rpc, rpc4;
    logic [31:0] cnt;
    logic [3:0]  cnt4;

    localparam logic [5:0]  ST_MEM  = 6'b001111;
    localparam logic [5:0]  FL_MEM  = 6'b010000;
    localparam logic [5:0]  FL_TRAP = 6'b011110;
    localparam logic [5:0]  FL_BR   = 6'b000110;
    localparam logic [5:0]  ST_LU   = 6'b000011;
    localparam logic [5:0]  FL_LU   = 6'b000100;
    localparam logic [5:0]  ST_IF   = 6'b000001;
    localparam logic [5:0]  FL_IF   = 6'b000010;
    localparam logic [63:0] TRAP_PC = 64'h8000_0100;
    localparam logic [63:0] BR_PC   = 64'h8000_0040;

    typedef struct {
        logic [5:0]  st;
        logic [5:0]  fl;
        logic        rv;
        logic [63:0] pc;
    } exp_t;

    exp_t        sb_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_cnt;
    logic [3:0]  exp_cnt4;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.REG_ADDRWIDTH(5), .CNT_WIDTH(32)) u_dut (
        .clk(clk), .rst(rst),
        .id_rs1_idx_i(id_rs1), .id_rs2_idx_i(id_rs2), .ex_rd_idx_i(ex_rd),
        .ex_is_load_i(ex_ld), .ex_branch_taken_i(br), .ex_branch_target_i(bt),
        .if_busy_i(busy), .mem_req_fire_i(fire), .mem_resp_valid_i(resp),
        .mem_trap_valid_i(trap), .trap_vector_i(tv),
        .stall_valid_o(stall), .flush_valid_o(flush), .redirect_valid_o(rv),
        .redirect_pc_o(rpc), .stall_cycles_o(cnt)
    );

    pipeline_hazard_ctrl #(.REG_ADDRWIDTH(5), .CNT_WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst),
        .id_rs1_idx_i(id_rs1), .id_rs2_idx_i(id_rs2), .ex_rd_idx_i(ex_rd),
        .ex_is_load_i(ex_ld), .ex_branch_taken_i(br), .ex_branch_target_i(bt),
        .if_busy_i(busy), .mem_req_fire_i(fire), .mem_resp_valid_i(resp),
        .mem_trap_valid_i(trap), .trap_vector_i(tv),
        .stall_valid_o(stall4), .flush_valid_o(flush4), .redirect_valid_o(rv4),
        .redirect_pc_o(rpc4), .stall_cycles_o(cnt4)
    );

    task automatic clear_inputs();
        id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
        ex_ld = 1'b0; br = 1'b0; busy = 1'b0;
        fire = 1'b0; resp = 1'b0; trap = 1'b0;
        bt = '0; tv = '0;
    endtask

    // Counter model advances on the edge closing every cycle expected to stall the PC.
    task automatic push_exp(input logic [5:0] s, input logic [5:0] f, input logic r,
                            input logic [63:0] p);
        exp_t e;
        e.st = s; e.fl = f; e.rv = r; e.pc = p;
        sb_q.push_back(e);
        if (s[0]) begin
            exp_cnt  = exp_cnt + 32'd1;
            exp_cnt4 = exp_cnt4 + 4'd1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        #1 rst = 1'b0;
        #2;
        exp_cnt  = '0;
        exp_cnt4 = '0;
        n_tests++;
        if ({stall, flush, rv, rpc, cnt} !== '0 || {stall4, flush4, rv4, rpc4, cnt4} !== '0) begin
            n_fail++;
            $display("FAIL reset: stall=%b flush=%b rv=%b pc=%h cnt=%0d cnt4=%0d, expected all zero",
                     stall, flush, rv, rpc, cnt, cnt4);
        end
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic test_load_use();
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            clear_inputs();
            case (i)
                0: begin ex_ld = 1; ex_rd = 5; id_rs2 = 5; push_exp(ST_LU, FL_LU, 0, 0); end
                1: push_exp(0, 0, 0, 0);
                2: begin ex_ld = 1; ex_rd = 0; push_exp(0, 0, 0, 0); end
                3: begin ex_ld = 1; ex_rd = 7; id_rs1 = 7; id_rs2 = 2; push_exp(ST_LU, FL_LU, 0, 0); end
                4: begin ex_ld = 1; ex_rd = 7; id_rs1 = 3; id_rs2 = 4; push_exp(0, 0, 0, 0); end
                default: ;
            endcase
            #2;
            e = sb_q.pop_front();
            n_tests++;
            if (stall !== e.st || flush !== e.fl || rv !== e.rv || rpc !== e.pc) begin
                n_fail++;
                $display("FAIL load_use[%0d]: got %b %b %b %h, expected %b %b %b %h",
                         i, stall, flush, rv, rpc, e.st, e.fl, e.rv, e.pc);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_fetch_wait();
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            clear_inputs();
            case (i)
                0: begin busy = 1; push_exp(ST_IF, FL_IF, 0, 0); end
                1: begin busy = 1; ex_ld = 1; ex_rd = 3; id_rs1 = 3; push_exp(ST_LU, FL_LU, 0, 0); end
                2: push_exp(0, 0, 0, 0);
                default: ;
            endcase
            #2;
            e = sb_q.pop_front();
            n_tests++;
            if (stall !== e.st || flush !== e.fl || rv !== e.rv || rpc !== e.pc) begin
                n_fail++;
                $display("FAIL fetch_wait[%0d]: got %b %b %b %h, expected %b %b %b %h",
                         i, stall, flush, rv, rpc, e.st, e.fl, e.rv, e.pc);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_mem_wait();
        exp_t e;
        for (int i = 0; i < 7; i++) begin
            clear_inputs();
            case (i)
                0: begin fire = 1; push_exp(ST_MEM, FL_MEM, 0, 0); end
                1, 2: push_exp(ST_MEM, FL_MEM, 0, 0);
                3: begin resp = 1; push_exp(0, 0, 0, 0); end
                4: push_exp(0, 0, 0, 0);
                5: begin fire = 1; resp = 1; push_exp(0, 0, 0, 0); end
                6: push_exp(0, 0, 0, 0);
                default: ;
            endcase
            #2;
            e = sb_q.pop_front();
            n_tests++;
            if (stall !== e.st || flush !== e.fl || rv !== e.rv || rpc !== e.pc) begin
                n_fail++;
                $display("FAIL mem_wait[%0d]: got %b %b %b %h, expected %b %b %b %h",
                         i, stall, flush, rv, rpc, e.st, e.fl, e.rv, e.pc);
            end
            @(posedge clk); #1;
        end
        n_tests++;
        if (cnt !== exp_cnt) begin
            n_fail++;
            $display("FAIL mem_wait_count: stall_cycles=%0d, expected %0d", cnt, exp_cnt);
        end
    endtask

    task automatic test_trap_wait();
        exp_t e;
        for (int i = 0; i < 6; i++) begin
            clear_inputs();
            case (i)
                0: begin fire = 1; push_exp(ST_MEM, FL_MEM, 0, 0); end
                1: begin trap = 1; tv = TRAP_PC; push_exp(ST_MEM, FL_MEM, 0, 0); end
                2: begin br = 1; bt = BR_PC; push_exp(ST_MEM, FL_MEM, 0, 0); end
                3: push_exp(ST_MEM, FL_MEM, 0, 0);
                4: begin resp = 1; tv = TRAP_PC; push_exp(0, FL_TRAP, 1, TRAP_PC); end
                5: push_exp(0, 0, 0, 0);
                default: ;
            endcase
            #2;
            e = sb_q.pop_front();
            n_tests++;
            if (stall !== e.st || flush !== e.fl || rv !== e.rv || rpc !== e.pc) begin
                n_fail++;
                $display("FAIL trap_wait[%0d]: got %b %b %b %h, expected %b %b %b %h",
                         i, stall, flush, rv, rpc, e.st, e.fl, e.rv, e.pc);
            end
            @(posedge clk); #1;
        end
        n_tests++;
        if (cnt !== exp_cnt) begin
            n_fail++;
            $display("FAIL trap_wait_count: stall_cycles=%0d, expected %0d", cnt, exp_cnt);
        end
    endtask

    task automatic test_priority();
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            clear_inputs();
            case (i)
                0: begin
                    br = 1; bt = BR_PC; ex_ld = 1; ex_rd = 5; id_rs1 = 5; busy = 1;
                    push_exp(0, FL_BR, 1, BR_PC);
                end
                1: begin
                    br = 1; bt = BR_PC; ex_ld = 1; ex_rd = 5; id_rs1 = 5; busy = 1;
                    trap = 1; tv = TRAP_PC;
                    push_exp(0, FL_TRAP, 1, TRAP_PC);
                end
                2: push_exp(0, 0, 0, 0);
                3: begin bt = 64'h1234; tv = 64'h5678; push_exp(0, 0, 0, 0); end
                default: ;
            endcase
            #2;
            e = sb_q.pop_front();
            n_tests++;
            if (stall !== e.st || flush !== e.fl || rv !== e.rv || rpc !== e.pc) begin
                n_fail++;
                $display("FAIL priority[%0d]: got %b %b %b %h, expected %b %b %b %h",
                         i, stall, flush, rv, rpc, e.st, e.fl, e.rv, e.pc);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        clear_inputs();
        fire = 1;
        push_exp(ST_MEM, FL_MEM, 0, 0);
        #2;
        e = sb_q.pop_front();
        n_tests++;
        if (stall !== e.st || flush !== e.fl || rv !== e.rv || rpc !== e.pc) begin
            n_fail++;
            $display("FAIL async_reset_fire: got %b %b %b %h, expected %b %b %b %h",
                     stall, flush, rv, rpc, e.st, e.fl, e.rv, e.pc);
        end
        @(posedge clk); #1;
        clear_inputs();
        #1 rst = 1'b0;
        exp_cnt  = '0;
        exp_cnt4 = '0;
        #1;
        n_tests++;
        if ({stall, flush, rv, rpc} !== '0 || cnt !== exp_cnt || cnt4 !== exp_cnt4) begin
            n_fail++;
            $display("FAIL async_reset: got %b %b %b %h cnt=%0d cnt4=%0d, expected zeros",
                     stall, flush, rv, rpc, cnt, cnt4);
        end
        @(posedge clk); #1 rst = 1'b1;
        #2;
        n_tests++;
        if ({stall, flush, rv, rpc} !== '0) begin
            n_fail++;
            $display("FAIL async_reset_release: got %b %b %b %h, expected zeros",
                     stall, flush, rv, rpc);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_counter_wrap();
        exp_t e;
        for (int i = 0; i < 17; i++) begin
            clear_inputs();
            busy = 1;
            push_exp(ST_IF, FL_IF, 0, 0);
            #2;
            e = sb_q.pop_front();
            n_tests++;
            if (stall !== e.st || flush !== e.fl || rv !== e.rv || rpc !== e.pc) begin
                n_fail++;
                $display("FAIL counter_wrap[%0d]: got %b %b %b %h, expected %b %b %b %h",
                         i, stall, flush, rv, rpc, e.st, e.fl, e.rv, e.pc);
            end
            @(posedge clk); #1;
        end
        clear_inputs();
        n_tests++;
        if (cnt4 !== exp_cnt4 || cnt !== exp_cnt) begin
            n_fail++;
            $display("FAIL counter_wrap_count: cnt4=%0d cnt=%0d, expected %0d %0d",
                     cnt4, cnt, exp_cnt4, exp_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_fetch_wait();
        test_mem_wait();
        test_trap_wait();
        test_priority();
        test_async_reset();
        test_counter_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
